// File: rtl/corwin_pkg.sv
// Shared types and constants for the sync-word correlator scheduler.
package corwin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int NREQ     = 3;
    localparam int REQ_CAC  = 0;
    localparam int REQ_DAC  = 1;
    localparam int REQ_GIAC = 2;

endpackage

// File: rtl/corwin_arb.sv
// Requester pick: CAC has fixed priority, DAC and GIAC share the correlator round-robin.
module corwin_arb
    import corwin_pkg::*;
(
    input  logic            clk_6M,
    input  logic            rstz,
    input  logic [NREQ-1:0] req_i,
    input  logic            grant_en_i,
    output logic [NREQ-1:0] grant_nxt_o
);

    // 0: DAC is preferred on a DAC/GIAC tie, 1: GIAC is preferred
    logic rr_giac_q;

    always_comb begin
        grant_nxt_o = '0;
        if (req_i[REQ_CAC]) begin
            grant_nxt_o[REQ_CAC] = 1'b1;
        end else if (req_i[REQ_DAC] && (!rr_giac_q || !req_i[REQ_GIAC])) begin
            grant_nxt_o[REQ_DAC] = 1'b1;
        end else if (req_i[REQ_GIAC]) begin
            grant_nxt_o[REQ_GIAC] = 1'b1;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            rr_giac_q <= 1'b0;
        end else if (grant_en_i && (grant_nxt_o[REQ_DAC] || grant_nxt_o[REQ_GIAC])) begin
            rr_giac_q <= grant_nxt_o[REQ_DAC];
        end
    end

endmodule

// File: rtl/corwin_sched.sv
// Correlator scheduler: grants one requester, drives the correlation window and
// reference sync word, and reports hit/miss per requester.
module corwin_sched
    import corwin_pkg::*;
#(
    parameter int WINW  = 10,
    parameter int SYNCW = 64
) (
    input  logic             clk_6M,
    input  logic             rstz,
    input  logic             p_1us,
    input  logic [2:0]       req,
    input  logic [SYNCW-1:0] sync0,
    input  logic [SYNCW-1:0] sync1,
    input  logic [SYNCW-1:0] sync2,
    input  logic [WINW-1:0]  regi_winlen0,
    input  logic [WINW-1:0]  regi_winlen1,
    input  logic [WINW-1:0]  regi_winlen2,
    input  logic             corre_trgp,
    output logic             correWindow,
    output logic [SYNCW-1:0] ref_sync,
    output logic [2:0]       grant,
    output logic [2:0]       hit_p,
    output logic [2:0]       miss_p,
    output logic             busy
);

    state_e            state_q;
    logic [WINW-1:0]   cnt_q;
    logic [WINW-1:0]   len_q;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   hit_q;
    logic [NREQ-1:0]   miss_q;
    logic              win_q;
    logic [SYNCW-1:0]  ref_q;

    logic [NREQ-1:0]   grant_nxt;
    logic              arb_en;
    logic [SYNCW-1:0]  sync_sel;
    logic [WINW-1:0]   len_sel;
    logic [WINW-1:0]   len_eff;
    logic              owner_live;

    assign arb_en     = (state_q == IDLE) && p_1us && (|req);
    assign owner_live = |(req & grant_q);

    corwin_arb u_arb (
        .clk_6M      (clk_6M),
        .rstz        (rstz),
        .req_i       (req),
        .grant_en_i  (arb_en),
        .grant_nxt_o (grant_nxt)
    );

    always_comb begin
        sync_sel = '0;
        len_sel  = '0;
        if (grant_nxt[REQ_CAC]) begin
            sync_sel = sync0;
            len_sel  = regi_winlen0;
        end else if (grant_nxt[REQ_DAC]) begin
            sync_sel = sync1;
            len_sel  = regi_winlen1;
        end else if (grant_nxt[REQ_GIAC]) begin
            sync_sel = sync2;
            len_sel  = regi_winlen2;
        end
    end

    // A programmed length of 0 behaves as a one-tick window
    assign len_eff = (len_sel == '0) ? WINW'(1) : len_sel;

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            grant_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            win_q   <= 1'b0;
            ref_q   <= '0;
        end else begin
            hit_q  <= '0;
            miss_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_en) begin
                        state_q <= OPEN;
                        grant_q <= grant_nxt;
                        win_q   <= 1'b1;
                        ref_q   <= sync_sel;
                        cnt_q   <= '0;
                        len_q   <= len_eff;
                    end
                end
                OPEN: begin
                    if (!owner_live) begin
                        state_q <= IDLE;
                        win_q   <= 1'b0;
                        grant_q <= '0;
                        ref_q   <= '0;
                    end else if (corre_trgp) begin
                        // grant and ref_sync stay up so the correlator keeps payload timing
                        state_q <= HOLD;
                        hit_q   <= grant_q;
                        win_q   <= 1'b0;
                    end else if (p_1us) begin
                        cnt_q <= cnt_q + WINW'(1);
                        if (cnt_q == len_q - WINW'(1)) begin
                            state_q <= IDLE;
                            miss_q  <= grant_q;
                            win_q   <= 1'b0;
                            grant_q <= '0;
                            ref_q   <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (!owner_live) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        ref_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    win_q   <= 1'b0;
                    grant_q <= '0;
                    ref_q   <= '0;
                end
            endcase
        end
    end

    assign correWindow = win_q;
    assign ref_sync    = ref_q;
    assign grant       = grant_q;
    assign hit_p       = hit_q;
    assign miss_p      = miss_q;
    assign busy        = (state_q != IDLE);

endmodule
